// File: rtl/seq_divider_pkg.sv
// Shared encodings for the RV32M sequential divider: op select, FSM states
// and iteration count.
package seq_divider_pkg;

  localparam int DIV_ITERS = 32;
  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/adder_32.sv
// 32-bit ripple adder with carry in/out, shared datapath block.
module adder_32 (
  input  logic [31:0] i_data1,
  input  logic [31:0] i_data2,
  input  logic        i_cin,
  output logic [31:0] o_sum,
  output logic        o_cout
);

  logic [32:0] w_full;

  assign w_full = {1'b0, i_data1} + {1'b0, i_data2} + 33'(i_cin);
  assign o_sum  = w_full[31:0];
  assign o_cout = w_full[32];

endmodule

// File: rtl/negative_num.sv
// Two's-complement negation of a 32-bit value (wraps for 0x80000000).
module negative_num (
  input  logic [31:0] i_data,
  output logic [31:0] o_data
);

  assign o_data = ~i_data + 32'd1;

endmodule

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep the result only if non-negative.
module seq_divider_div_step (
  input  logic [31:0] i_rem,
  input  logic [31:0] i_quo,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_rem,
  output logic [31:0] o_quo
);

  logic [32:0] w_shift;
  logic [31:0] w_sum;
  logic        w_cout;
  logic [32:0] w_trial;
  logic        w_ge;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // remainder while the new quotient bit enters at the LSB.
  assign w_shift = {i_rem, i_quo[31]};

  adder_32 u_add (
    .i_data1 (w_shift[31:0]),
    .i_data2 (~i_divisor),
    .i_cin   (1'b1),
    .o_sum   (w_sum),
    .o_cout  (w_cout)
  );

  // Bit 32 of the trial: shift[32] + 1 (extended ~divisor) + carry.
  assign w_trial = {w_shift[32] ^ ~w_cout, w_sum};
  assign w_ge    = ~w_trial[32];

  assign o_rem = w_ge ? w_trial[31:0] : w_shift[31:0];
  assign o_quo = {i_quo[30:0], w_ge};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring, fixed
// 33-cycle latency from accepted start to done.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_e  r_state;
  div_state_e  w_state_next;
  logic [4:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_dvd_orig;
  logic [31:0] r_dvs;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [31:0] r_result;
  logic        r_q_neg;
  logic        r_r_neg;
  logic        r_div0;

  logic        w_accept;
  logic        w_signed;
  logic        w_dvd_neg;
  logic        w_dvs_neg;
  logic [31:0] w_neg_a_in;
  logic [31:0] w_neg_a;
  logic [31:0] w_neg_b;
  logic [31:0] w_rem_next;
  logic [31:0] w_quo_next;
  logic        w_fix_neg;
  logic [31:0] w_fix_val;

  assign w_accept  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_signed  = op_is_signed(op);
  assign w_dvd_neg = w_signed & dividend[31];
  assign w_dvs_neg = w_signed & divisor[31];

  // Negator A serves the dividend absolute value on accept and the result
  // sign fix in FIX; the two uses never overlap in time.
  assign w_neg_a_in = (r_state == ST_FIX) ? (op_is_rem(r_op) ? r_rem : r_quo)
                                          : dividend;

  negative_num u_neg_a (
    .i_data (w_neg_a_in),
    .o_data (w_neg_a)
  );

  negative_num u_neg_b (
    .i_data (divisor),
    .o_data (w_neg_b)
  );

  seq_divider_div_step u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_next),
    .o_quo     (w_quo_next)
  );

  always_comb begin
    w_fix_neg = op_is_rem(r_op) ? r_r_neg : r_q_neg;
    w_fix_val = w_fix_neg ? w_neg_a : w_neg_a_in;
    if (r_div0) begin
      w_fix_val = op_is_rem(r_op) ? r_dvd_orig : 32'hFFFF_FFFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_next = ST_CALC;
      ST_CALC: if (r_cnt == LAST_ITER) w_state_next = ST_FIX;
      ST_FIX:  w_state_next = ST_DONE;
      ST_DONE: w_state_next = start ? ST_CALC : ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_op       <= '0;
      r_dvd_orig <= '0;
      r_dvs      <= '0;
      r_quo      <= '0;
      r_rem      <= '0;
      r_result   <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_div0     <= 1'b0;
    end else if (w_accept) begin
      r_cnt      <= '0;
      r_op       <= op;
      r_dvd_orig <= dividend;
      r_quo      <= w_dvd_neg ? w_neg_a : dividend;
      r_dvs      <= w_dvs_neg ? w_neg_b : divisor;
      r_rem      <= '0;
      r_q_neg    <= w_dvd_neg ^ w_dvs_neg;
      r_r_neg    <= w_dvd_neg;
      r_div0     <= (divisor == '0);
    end else if (r_state == ST_CALC) begin
      r_cnt <= r_cnt + 5'd1;
      r_rem <= w_rem_next;
      r_quo <= w_quo_next;
    end else if (r_state == ST_FIX) begin
      r_result <= w_fix_val;
    end
  end

  assign busy   = (r_state == ST_CALC) || (r_state == ST_FIX);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: arithmetic, corner cases,
// latency, ignored start, back-to-back and mid-operation reset.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail = 0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  seq_divider #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Launch one op and count edges from the accepting edge to done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    op = o; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    res = result;
    $display("op=%0d a=%08h b=%08h -> result=%08h latency=%0d", o, a, b, res, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result got=%08h exp=00000000", result); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [31:0] r; int lat;
    run_op(DIVU, 32'd100, 32'd7, r, lat);
    n_checks++; if (r !== 32'd14) begin n_fail++; $display("FAIL divu_100_7 got=%08h exp=0000000e", r); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL divu_latency got=%0d exp=33", lat); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done got=%b exp=0", busy); end
    @(posedge clk); #1;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got=%b exp=0", done); end
    repeat (3) @(posedge clk); #1;
    n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL result_hold got=%08h exp=0000000e", result); end
    run_op(REMU, 32'd100, 32'd7, r, lat);
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL remu_100_7 got=%08h exp=00000002", r); end
  endtask

  task automatic test_signed();
    logic [31:0] r; int lat;
    run_op(DIV, 32'hFFFF_FFF9, 32'd2, r, lat);
    n_checks++; if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_m7_2 got=%08h exp=fffffffd", r); end
    run_op(REM, 32'hFFFF_FFF9, 32'd2, r, lat);
    n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_m7_2 got=%08h exp=ffffffff", r); end
    run_op(REM, 32'd7, 32'hFFFF_FFFE, r, lat);
    n_checks++; if (r !== 32'd1) begin n_fail++; $display("FAIL rem_7_m2 got=%08h exp=00000001", r); end
    run_op(DIV, 32'd7, 32'hFFFF_FFFE, r, lat);
    n_checks++; if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_7_m2 got=%08h exp=fffffffd", r); end
  endtask

  task automatic test_overflow();
    logic [31:0] r; int lat;
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    n_checks++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL div_overflow got=%08h exp=80000000", r); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL overflow_latency got=%0d exp=33", lat); end
    run_op(REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL rem_overflow got=%08h exp=00000000", r); end
  endtask

  task automatic test_div0();
    logic [31:0] r; int lat;
    run_op(DIVU, 32'd5, 32'd0, r, lat);
    n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_by0 got=%08h exp=ffffffff", r); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL div0_latency got=%0d exp=33", lat); end
    run_op(REM, 32'hFFFF_FFFB, 32'd0, r, lat);
    n_checks++; if (r !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL rem_by0 got=%08h exp=fffffffb", r); end
    run_op(DIV, 32'hFFFF_FFFB, 32'd0, r, lat);
    n_checks++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_by0 got=%08h exp=ffffffff", r); end
  endtask

  task automatic test_ignore_start();
    int lat;
    @(negedge clk);
    op = DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
      if (i == 10) begin
        op = DIV; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    $display("ignore_start: result=%08h latency=%0d", result, lat);
    n_checks++; if (result !== 32'd14) begin n_fail++; $display("FAIL ignore_start_result got=%08h exp=0000000e", result); end
    n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL ignore_start_latency got=%0d exp=33", lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat; int gap;
    run_op(DIVU, 32'd100, 32'd7, r, lat);
    // Still inside the DONE cycle: present the next request now.
    op = DIVU; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got=%b exp=1", busy); end
    gap = -1;
    for (int i = 2; i <= 100; i++) begin
      @(posedge clk); #1;
      if (done) begin gap = i; break; end
    end
    $display("back_to_back: result=%08h done_gap=%0d", result, gap);
    n_checks++; if (gap !== 34) begin n_fail++; $display("FAIL b2b_gap got=%0d exp=34", gap); end
    n_checks++; if (result !== 32'd3) begin n_fail++; $display("FAIL b2b_result got=%08h exp=00000003", result); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat; int seen;
    @(negedge clk);
    op = DIVU; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL midreset_result got=%08h exp=00000000", result); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    $display("reset_mid: done_after_abort=%0d", seen);
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midreset_no_done got=%0d exp=0", seen); end
    run_op(DIVU, 32'd9, 32'd3, r, lat);
    n_checks++; if (r !== 32'd3) begin n_fail++; $display("FAIL post_reset_divu got=%08h exp=00000003", r); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div0();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle RV32M integer divider for the RV32I CPU execute stage, covering DIV, DIVU, REM and REMU. It runs a radix-2 restoring algorithm, one quotient bit per clock, with a fixed latency for every operand combination. It is the sequential inverse counterpart to the combinational adder/negation datapath, and it reuses those blocks for trial subtraction and sign correction. The execute stage holds the pipeline while `busy` is high.

## Interface
Parameters:
- `XLEN`, 32, operand and result width; only 32 is supported.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: request; sampled only in IDLE or DONE.
- `op` input 2: operation select. 00 = DIV, 01 = DIVU, 10 = REM, 11 = REMU.
- `dividend` input 32: rs1 value, sampled with `start`.
- `divisor` input 32: rs2 value, sampled with `start`.
- `busy` output 1: high in CALC and FIX.
- `done` output 1: one-cycle pulse; high only in DONE.
- `result` output 32: quotient or remainder; valid from `done` until the next accepted `start`.

## Operation
States:
- IDLE: waits for a request. `start` = 1 moves to CALC.
- CALC: performs 32 iterations, counted by a 5-bit counter from 0 to 31. The last iteration moves to FIX.
- FIX: applies the sign and special-case corrections for one cycle, then moves to DONE.
- DONE: holds for one cycle. `start` = 1 moves to CALC, otherwise the block returns to IDLE.

Operand handling on acceptance:
- `op`, `dividend` and `divisor` are latched.
- Signed ops (op[0] = 0) convert each operand to its absolute value with two's-complement negation.
- The block records `q_neg = sign(dividend) XOR sign(divisor)` and `r_neg = sign(dividend)`.
- It also records `div0 = (divisor == 0)`.

Each CALC iteration:
- Shift the 33-bit partial remainder left, bringing in the next dividend MSB.
- Compute `trial = rem - divisor` with adder_32 (cin = 1, data2 = ~divisor, extended by one bit).
- If `trial` is non-negative, set `rem = trial` and the quotient bit to 1; otherwise keep `rem` and set the quotient bit to 0.

FIX rules, all on 32-bit wrap-around arithmetic:
- Quotient ops: `result = q_neg ? -q : q`.
- Remainder ops: `result = r_neg ? -r : r`.
- If `div0` is set, override: quotient = 0xFFFFFFFF and remainder = the original dividend, for both signed and unsigned ops.
- Signed overflow (0x80000000 / 0xFFFFFFFF) needs no override. It yields quotient 0x80000000 and remainder 0 naturally.

Other behaviour:
- `start` while `busy` is high is ignored. Latched operands and the result are unaffected.
- Asserting `rst_n` low at any point, including mid-CALC, forces IDLE immediately. `busy`, `done`, `result`, the counter and all datapath registers go to 0. The aborted operation produces no `done`.

## Timing
- Reset values: `busy` = 0, `done` = 0, `result` = 0x00000000, state IDLE.
- `start` is sampled at edge E0. `busy` is high after E0. The 32 iterations happen on edges E1 to E32. FIX happens on E33. `done` is high and `result` valid after E33. Latency is 33 cycles.
- Latency is identical for all operands, including divide-by-zero and overflow. There is no early termination.
- `busy` falls on the same edge that `done` rises.
- `start` during DONE is accepted: `busy` rises on the next edge, giving back-to-back throughput of 1 op per 34 cycles.
- `result` is registered and holds its value until the FIX stage of the next operation; it is not cleared when DONE exits.
- `done` is never high for more than one consecutive cycle unless a back-to-back op completes, which is at least 34 cycles later.

## Structure
Shared package/header holds:
- op encodings DIV/DIVU/REM/REMU.
- the state encoding (IDLE, CALC, FIX, DONE; 2 bits).
- the constant `DIV_ITERS = 32`.

Sub-modules:
- One adder_32 instance for the trial subtraction.
- negative_num instances for absolute value and sign fix, shared through a mux.

One natural new sub-module is `div_step`, the combinational shift/trial-subtract/select for a single iteration. It keeps the FSM in `seq_divider` thin.

## Test plan
- DIVU 100 / 7 -> `result` = 14 with `done` exactly 33 cycles after `start`. REMU on the same operands -> 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD (-3). REM on the same operands -> 0xFFFFFFFF (-1). REM 7 / 0xFFFFFFFE (-2) -> 1.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM on the same operands -> 0x00000000.
- DIVU 5 / 0 -> 0xFFFFFFFF. REM 0xFFFFFFFB / 0 -> 0xFFFFFFFB. Latency is still 33 cycles.
- Re-pulse `start` with new operands at cycle 10 of a busy op -> ignored, original result returned. `start` asserted in the DONE cycle -> new op accepted, `done` again 34 cycles after the first `done`.
- Drive `rst_n` low at CALC iteration 15 -> `busy` = 0, `result` = 0 immediately, no `done`. After release, DIVU 9 / 3 -> 3.
